gpo_pad_ctrl: RTL
=================

// Module: gpo_pad_ctrl
// PURPOSE
//  Core-side controller directly upstream of one EG1 1.8V GPO pad cell; drives its DO/DS/SR/CO/OE/ODP/ODN pins.
//  Config changes (drive strength, slew, mode, enable) are applied only through a glitch-safe sequence:
//  quiesce OE, apply, wait for VBIAS-ready when DS!=00, settle, re-enable. Data path is a registered DO.
//  Bias loss at runtime falls back to DS=00 and sets a sticky error flag.
// PARAMETERS
//  GUARD_CYC     4     cycles with oe_o=0 before new config is applied (min 1)
//  SETTLE_CYC    8     cycles after apply/bias-ok before oe_o is restored (min 1)
//  BIAS_TMO_CYC  256   max cycles waiting for bias_ok when DS!=00 before fallback
// PORTS
//  clk_i         in   1  core clock
//  rst_ni        in   1  synchronous active-low reset
//  cfg_valid_i   in   1  new pad configuration offered
//  cfg_ready_o   out  1  config accepted when cfg_valid_i & cfg_ready_o
//  cfg_ds_i      in   2  drive strength (00 needs no bias)
//  cfg_sr_i      in   1  slew-rate select
//  cfg_co_i      in   1  CO select, passed through
//  cfg_mode_i    in   2  00 push-pull, 01 open-drain (ODP=1), 10 open-source (ODN=1), 11 = push-pull
//  cfg_oe_i      in   1  output enable requested
//  data_i        in   1  output data bit
//  bias_ok_i     in   1  async VBIAS-ready level; 2-flop synchronised internally
//  do_o          out  1  to pad DO_I
//  ds_o          out  2  to pad DS_I
//  sr_o/co_o     out  1  to pad SR_I / CO_I
//  oe_o          out  1  to pad OE_I
//  odp_o/odn_o   out  1  to pad ODP_I / ODN_I
//  busy_o        out  1  sequence in progress (state != ACTIVE)
//  err_bias_o    out  1  sticky: bias timeout or runtime bias loss; cleared by a cfg handshake with cfg_ds_i=00
// BEHAVIOUR
//  Reset (rst_ni=0 at posedge): all outputs 0 (ds_o=00, oe_o=0, do_o=0, odp/odn=0), err=0, bias sync=0, state=ACTIVE.
//  ACTIVE: cfg_ready_o=1, busy_o=0. do_o<=data_i each cycle (1-cycle latency); oe_o = registered cfg OE.
//   Handshake: capture cfg_* into pending regs, go to QUIESCE next cycle. cfg_ready_o=0 in all other states.
//  QUIESCE: oe_o=0 from first cycle; count GUARD_CYC; do_o holds. Then APPLY.
//  APPLY (1 cycle): ds/sr/co/odp/odn outputs <= pending; odp=(mode==01), odn=(mode==10).
//   Next: BIAS_WAIT if pending ds!=00, else SETTLE.
//  BIAS_WAIT: synced bias_ok=1 -> SETTLE. After BIAS_TMO_CYC cycles without it: ds_o<=00, err_bias_o<=1 -> SETTLE.
//  SETTLE: count SETTLE_CYC; then oe_o<=pending oe, ACTIVE. First DO update is on the ACTIVE cycle.
//  Runtime bias loss: in ACTIVE with ds_o!=00 and synced bias_ok=0 -> err_bias_o<=1, pending ds<=00,
//   other pending = current, go QUIESCE (oe_o=0 next cycle). cfg_valid_i in the same cycle is not accepted.
//  cfg_valid_i while busy: held off (ready=0); upstream must hold cfg stable until accepted.
//  Counters: single down-counter sized $clog2(max(GUARD,SETTLE,BIAS_TMO)+1); reloaded on each state entry, no wrap.
//  Reset mid-sequence: immediate return to reset values; pending config discarded.
//  Invariant: oe_o is never 1 in the cycle any of ds_o/sr_o/co_o/odp_o/odn_o changes.
// TESTING
//  Reset then idle: all outputs 0, cfg_ready_o=1, busy_o=0; data_i toggles -> do_o follows 1 cycle later.
//  cfg ds=00,mode=00,oe=1 -> oe_o=0 for 4 cycles, ds applied, 8 settle cycles, oe_o=1 at cycle 14 after accept.
//  cfg ds=11, bias_ok rises 20 cycles after accept -> ds_o=11, oe_o=1 only after sync+8 settle cycles, err=0.
//  cfg ds=10, bias_ok stuck 0 -> after 256 wait cycles ds_o=00, err_bias_o=1, oe_o restored; ds=00 cfg clears err.
//  ACTIVE ds=01, bias_ok drops -> oe_o=0 within 3 cycles (sync + 1), ds_o=00, err=1, mode/sr unchanged.
//  mode=01 -> odp_o=1, odn_o=0; rst_ni=0 asserted mid-SETTLE -> all outputs 0 next cycle, ACTIVE.

Source files
------------

// File: rtl/gpo_pad_ctrl_if.sv
// Pad configuration handshake between the core and gpo_pad_ctrl.
// The master holds cfg fields stable while cfg_valid is high and cfg_ready is low.
interface gpo_pad_ctrl_if;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_ds;
  logic       cfg_sr;
  logic       cfg_co;
  logic [1:0] cfg_mode;
  logic       cfg_oe;

  modport master (
    output cfg_valid, cfg_ds, cfg_sr, cfg_co, cfg_mode, cfg_oe,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ds, cfg_sr, cfg_co, cfg_mode, cfg_oe,
    output cfg_ready
  );
endinterface

// File: rtl/gpo_pad_ctrl.sv
// Glitch-safe controller for one EG1 1.8V GPO pad: quiesce, apply, bias-wait, settle, re-enable.
// Latency: do_o 1 cycle in ACTIVE; new config reaches oe_o GUARD+1+SETTLE cycles (plus bias wait) after accept.
// Backpressure: cfg_ready low while a sequence runs and in the cycle a bias loss is taken.
module gpo_pad_ctrl #(
  parameter int unsigned GUARD_CYC    = 4,
  parameter int unsigned SETTLE_CYC   = 8,
  parameter int unsigned BIAS_TMO_CYC = 256
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  gpo_pad_ctrl_if.slave cfg,
  input  logic          data_i,
  input  logic          bias_ok_i,
  output logic          do_o,
  output logic [1:0]    ds_o,
  output logic          sr_o,
  output logic          co_o,
  output logic          oe_o,
  output logic          odp_o,
  output logic          odn_o,
  output logic          busy_o,
  output logic          err_bias_o
);

  localparam int unsigned MAX_GS  = (GUARD_CYC > SETTLE_CYC) ? GUARD_CYC : SETTLE_CYC;
  localparam int unsigned MAX_CYC = (MAX_GS > BIAS_TMO_CYC) ? MAX_GS : BIAS_TMO_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] GUARD_LD  = CNT_W'(GUARD_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LD    = CNT_W'(BIAS_TMO_CYC - 1);

  typedef enum logic [2:0] {
    ST_ACTIVE,
    ST_QUIESCE,
    ST_APPLY,
    ST_BIAS_WAIT,
    ST_SETTLE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bias_s1, bias_s2;
  logic             bias_loss;

  logic [1:0] pend_ds_q, pend_ds_d;
  logic       pend_sr_q, pend_sr_d;
  logic       pend_co_q, pend_co_d;
  logic       pend_odp_q, pend_odp_d;
  logic       pend_odn_q, pend_odn_d;
  logic       pend_oe_q, pend_oe_d;

  logic       do_d, sr_d, co_d, oe_d, odp_d, odn_d, err_d;
  logic [1:0] ds_d;

  assign busy_o = (state_q != ST_ACTIVE);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pend_ds_d     = pend_ds_q;
    pend_sr_d     = pend_sr_q;
    pend_co_d     = pend_co_q;
    pend_odp_d    = pend_odp_q;
    pend_odn_d    = pend_odn_q;
    pend_oe_d     = pend_oe_q;
    do_d          = do_o;
    ds_d          = ds_o;
    sr_d          = sr_o;
    co_d          = co_o;
    oe_d          = oe_o;
    odp_d         = odp_o;
    odn_d         = odn_o;
    err_d         = err_bias_o;
    bias_loss     = 1'b0;
    cfg.cfg_ready = 1'b0;

    case (state_q)
      ST_ACTIVE: begin
        do_d          = data_i;
        bias_loss     = (ds_o != 2'b00) && !bias_s2;
        cfg.cfg_ready = !bias_loss;
        if (bias_loss) begin
          // Re-run the sequence with the current pad settings but no bias-dependent drive.
          err_d      = 1'b1;
          pend_ds_d  = 2'b00;
          pend_sr_d  = sr_o;
          pend_co_d  = co_o;
          pend_odp_d = odp_o;
          pend_odn_d = odn_o;
          pend_oe_d  = oe_o;
          oe_d       = 1'b0;
          cnt_d      = GUARD_LD;
          state_d    = ST_QUIESCE;
        end else if (cfg.cfg_valid) begin
          pend_ds_d  = cfg.cfg_ds;
          pend_sr_d  = cfg.cfg_sr;
          pend_co_d  = cfg.cfg_co;
          pend_odp_d = (cfg.cfg_mode == 2'b01);
          pend_odn_d = (cfg.cfg_mode == 2'b10);
          pend_oe_d  = cfg.cfg_oe;
          if (cfg.cfg_ds == 2'b00) err_d = 1'b0;
          oe_d       = 1'b0;
          cnt_d      = GUARD_LD;
          state_d    = ST_QUIESCE;
        end
      end
      ST_QUIESCE: begin
        if (cnt_q == '0) state_d = ST_APPLY;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_APPLY: begin
        ds_d  = pend_ds_q;
        sr_d  = pend_sr_q;
        co_d  = pend_co_q;
        odp_d = pend_odp_q;
        odn_d = pend_odn_q;
        if (pend_ds_q != 2'b00) begin
          cnt_d   = TMO_LD;
          state_d = ST_BIAS_WAIT;
        end else begin
          cnt_d   = SETTLE_LD;
          state_d = ST_SETTLE;
        end
      end
      ST_BIAS_WAIT: begin
        if (bias_s2) begin
          cnt_d   = SETTLE_LD;
          state_d = ST_SETTLE;
        end else if (cnt_q == '0) begin
          ds_d    = 2'b00;
          err_d   = 1'b1;
          cnt_d   = SETTLE_LD;
          state_d = ST_SETTLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          oe_d    = pend_oe_q;
          state_d = ST_ACTIVE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_ACTIVE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_ACTIVE;
      cnt_q      <= '0;
      bias_s1    <= 1'b0;
      bias_s2    <= 1'b0;
      pend_ds_q  <= 2'b00;
      pend_sr_q  <= 1'b0;
      pend_co_q  <= 1'b0;
      pend_odp_q <= 1'b0;
      pend_odn_q <= 1'b0;
      pend_oe_q  <= 1'b0;
      do_o       <= 1'b0;
      ds_o       <= 2'b00;
      sr_o       <= 1'b0;
      co_o       <= 1'b0;
      oe_o       <= 1'b0;
      odp_o      <= 1'b0;
      odn_o      <= 1'b0;
      err_bias_o <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bias_s1    <= bias_ok_i;
      bias_s2    <= bias_s1;
      pend_ds_q  <= pend_ds_d;
      pend_sr_q  <= pend_sr_d;
      pend_co_q  <= pend_co_d;
      pend_odp_q <= pend_odp_d;
      pend_odn_q <= pend_odn_d;
      pend_oe_q  <= pend_oe_d;
      do_o       <= do_d;
      ds_o       <= ds_d;
      sr_o       <= sr_d;
      co_o       <= co_d;
      oe_o       <= oe_d;
      odp_o      <= odp_d;
      odn_o      <= odn_d;
      err_bias_o <= err_d;
    end
  end

endmodule
